// File: rtl/tof_sched_pkg.sv
// -----------------------------------------------------------------------------
// tof_sched_pkg
// Shared definitions for the ToF ranging scheduler and its neighbours.
//   TOF_CNT_W      : width of one ToF count. The ToF timer and the bit shifter
//                    use this same width.
//   sched_state_t  : scheduler FSM states.
//   max_int()      : elaboration-time helper for sizing counters.
// -----------------------------------------------------------------------------
package tof_sched_pkg;

    localparam int TOF_CNT_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_MEAS,
        S_GUARD,
        S_AVERAGE,
        S_PRESENT
    } sched_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tof_cycle_timer.sv
// -----------------------------------------------------------------------------
// tof_cycle_timer
// Loadable down-counter. It counts from the loaded value down to zero and then
// holds at zero. The expiry flag is high while the count is zero. A load of N-1
// therefore flags expiry in the N-th cycle after the load edge.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   i_load         : load i_value on the next edge (wins over counting)
//   i_value        : value to load
//   o_expired      : count has reached zero
// -----------------------------------------------------------------------------
module tof_cycle_timer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values of the others.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/tof_ranging_scheduler.sv
// -----------------------------------------------------------------------------
// tof_ranging_scheduler
// Runs 2^LOG2_SAMPLES time-of-flight shots and presents their mean value.
// For each shot it arms the ToF timer and waits for a done pulse or a timeout.
// It then waits a TX settling guard before the next shot. Timeouts are retried
// up to MAX_RETRY consecutive times, after which the session ends with an
// error result.
// Ports:
//   clock, reset_n  : clock and asynchronous active-low reset
//   start           : session request, only sampled in IDLE
//   abort           : synchronous abort to IDLE, highest priority
//   meas_arm        : one-cycle arm pulse to the ToF timer
//   meas_done       : one-cycle pulse qualifying meas_value
//   meas_value      : measured count
//   res_valid       : result valid (valid/ready handshake with res_ready)
//   res_ready       : consumer accepts the result
//   res_data        : averaged count, or 0 on error
//   res_error       : session failed; qualified by res_valid
//   busy            : high outside IDLE
//   sample_idx      : index of the sample in progress
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module tof_ranging_scheduler
    import tof_sched_pkg::*;
#(
    parameter int CNT_W          = TOF_CNT_W,
    parameter int LOG2_SAMPLES   = 2,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int GUARD_CYCLES   = 10_000_000,
    parameter int MAX_RETRY      = 3
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    output logic                    meas_arm,
    input  logic                    meas_done,
    input  logic [CNT_W-1:0]        meas_value,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [CNT_W-1:0]        res_data,
    output logic                    res_error,
    output logic                    busy,
    output logic [LOG2_SAMPLES-1:0] sample_idx
);

    localparam int ACC_W   = CNT_W + LOG2_SAMPLES;
    // The timer is loaded with N-1, so clog2 of the largest N is wide enough.
    localparam int TMR_W   = $clog2(max_int(TIMEOUT_CYCLES, GUARD_CYCLES));
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [TMR_W-1:0]        TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]        GUARD_LOAD   = TMR_W'(GUARD_CYCLES - 1);
    localparam logic [LOG2_SAMPLES-1:0] LAST_IDX     = '1;
    localparam logic [RETRY_W-1:0]      RETRY_LAST   = RETRY_W'(MAX_RETRY - 1);

    sched_state_t            r_state;
    logic [ACC_W-1:0]        r_acc;
    logic [RETRY_W-1:0]      r_retry;
    logic [LOG2_SAMPLES-1:0] r_sample_idx;
    logic                    r_meas_arm;
    logic                    r_res_valid;
    logic [CNT_W-1:0]        r_res_data;
    logic                    r_res_error;
    logic                    r_busy;

    logic                    w_timer_load;
    logic [TMR_W-1:0]        w_timer_value;
    logic                    w_expired;

    // The ARM cycle loads the timeout. Leaving WAIT_MEAS loads the guard. On
    // the exits to AVERAGE and PRESENT that load is unused and harmless.
    assign w_timer_load  = (r_state == S_ARM) ||
                           ((r_state == S_WAIT_MEAS) && (meas_done || w_expired));
    assign w_timer_value = (r_state == S_ARM) ? TIMEOUT_LOAD : GUARD_LOAD;

    tof_cycle_timer #(
        .W (TMR_W)
    ) u_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_load    (w_timer_load),
        .i_value   (w_timer_value),
        .o_expired (w_expired)
    );

    // Outputs are registered as the FSM leaves a state. As a result, meas_arm
    // and res_valid each appear one cycle after ARM and PRESENT are entered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_retry      <= '0;
            r_sample_idx <= '0;
            r_meas_arm   <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_error  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // NOTE: pulse output defaults low each cycle, and only ARM raises it.
            r_meas_arm <= 1'b0;
            if (abort) begin
                r_state      <= S_IDLE;
                r_res_valid  <= 1'b0;
                r_busy       <= 1'b0;
                r_acc        <= '0;
                r_retry      <= '0;
                r_sample_idx <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_acc        <= '0;
                            r_retry      <= '0;
                            r_sample_idx <= '0;
                            r_busy       <= 1'b1;
                            r_state      <= S_ARM;
                        end
                    end
                    S_ARM: begin
                        r_meas_arm <= 1'b1;
                        r_state    <= S_WAIT_MEAS;
                    end
                    S_WAIT_MEAS: begin
                        // A done in the expiry cycle still counts as a sample.
                        if (meas_done) begin
                            r_acc   <= r_acc + ACC_W'(meas_value);
                            r_retry <= '0;
                            if (r_sample_idx == LAST_IDX) begin
                                r_state <= S_AVERAGE;
                            end else begin
                                r_sample_idx <= r_sample_idx + LOG2_SAMPLES'(1);
                                r_state      <= S_GUARD;
                            end
                        end else if (w_expired) begin
                            r_retry <= r_retry + RETRY_W'(1);
                            if (r_retry == RETRY_LAST) begin
                                r_res_data  <= '0;
                                r_res_error <= 1'b1;
                                r_state     <= S_PRESENT;
                            end else begin
                                r_state <= S_GUARD;
                            end
                        end
                    end
                    S_GUARD: begin
                        if (w_expired) begin
                            r_state <= S_ARM;
                        end
                    end
                    S_AVERAGE: begin
                        // Dividing by 2^LOG2_SAMPLES is a slice of the upper bits, which truncates.
                        r_res_data  <= r_acc[ACC_W-1:LOG2_SAMPLES];
                        r_res_error <= 1'b0;
                        r_state     <= S_PRESENT;
                    end
                    S_PRESENT: begin
                        if (r_res_valid && res_ready) begin
                            r_res_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_res_valid <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign meas_arm   = r_meas_arm;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign res_error  = r_res_error;
    assign busy       = r_busy;
    assign sample_idx = r_sample_idx;

endmodule

// File: tb/tb_tof_ranging_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tof_ranging_scheduler
// Self-checking bench for tof_ranging_scheduler. Parameters: LOG2_SAMPLES=2,
// TIMEOUT_CYCLES=100, GUARD_CYCLES=4, MAX_RETRY=2.
// A table of session records (sample values, done delays, leading timeouts,
// expected result) runs through one session task. Hand-written sequences cover
// backpressure, abort and reset in the middle of GUARD.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_tof_ranging_scheduler;

    localparam int CNT_W   = 32;
    localparam int LOG2_S  = 2;
    localparam int TIMEOUT = 100;
    localparam int GUARD   = 4;
    localparam int RETRIES = 2;

    logic              clock;
    logic              reset_n;
    logic              start;
    logic              abort;
    logic              meas_arm;
    logic              meas_done;
    logic [CNT_W-1:0]  meas_value;
    logic              res_valid;
    logic              res_ready;
    logic [CNT_W-1:0]  res_data;
    logic              res_error;
    logic              busy;
    logic [LOG2_S-1:0] sample_idx;

    tof_ranging_scheduler #(
        .CNT_W          (CNT_W),
        .LOG2_SAMPLES   (LOG2_S),
        .TIMEOUT_CYCLES (TIMEOUT),
        .GUARD_CYCLES   (GUARD),
        .MAX_RETRY      (RETRIES)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .meas_arm   (meas_arm),
        .meas_done  (meas_done),
        .meas_value (meas_value),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_error  (res_error),
        .busy       (busy),
        .sample_idx (sample_idx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string            name;
        logic [3:0][31:0] val;      // done values, index 0 first
        logic [3:0][7:0]  dly;      // cycles between arm sighting and done pulse
        int               n_to;     // leading shots left to time out
        bit               exp_err;
        logic [31:0]      exp_data;
        int               exp_arms;
    } sess_vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int arm_cnt = 0;
    int last_arm_cyc = 0;
    int last_gap = 0;

    sess_vec_t vecs[6];

    function automatic sess_vec_t mk(input string n, input logic [3:0][31:0] v,
                                     input logic [3:0][7:0] d, input int nto,
                                     input bit err, input logic [31:0] ed, input int ea);
        sess_vec_t r;
        r.name = n; r.val = v; r.dly = d; r.n_to = nto;
        r.exp_err = err; r.exp_data = ed; r.exp_arms = ea;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of progress: advance to the falling edge and log any arm pulse.
    task automatic step();
        @(negedge clock);
        cyc++;
        if (meas_arm) begin
            if (arm_cnt > 0) last_gap = cyc - last_arm_cyc;
            last_arm_cyc = cyc;
            arm_cnt++;
        end
    endtask

    task automatic wait_arm(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (meas_arm) begin
                ok = 1'b1;
                break;
            end
        end
        check("arm_seen", ok, 1);
    endtask

    task automatic pulse_done(input logic [31:0] v);
        meas_done  = 1'b1;
        meas_value = v;
        step();
        meas_done  = 1'b0;
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check($sformatf("%s.hs_valid_drop", tag), res_valid, 0);
        check($sformatf("%s.hs_idle", tag), busy, 0);
    endtask

    // Runs one session up to the point where res_valid is high (no handshake).
    task automatic do_session(input sess_vec_t v);
        int shots;
        int gap_exp;
        bit ok;
        bit seen;
        shots   = v.n_to + (v.exp_err ? 0 : 4);
        gap_exp = 0;
        arm_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        check($sformatf("%s.busy_start", v.name), busy, 1);
        check($sformatf("%s.arm_early", v.name), meas_arm, 0);
        step();
        check($sformatf("%s.arm_latency", v.name), meas_arm, 1);
        for (int s = 0; s < shots; s++) begin
            if (s > 0) begin
                wait_arm(ok);
                check($sformatf("%s.gap%0d", v.name, s), last_gap, gap_exp);
            end
            check($sformatf("%s.idx%0d", v.name, s), sample_idx,
                  (s < v.n_to) ? 0 : s - v.n_to);
            if (s < v.n_to) begin
                gap_exp = TIMEOUT + GUARD + 1;
            end else begin
                int k;
                k = s - v.n_to;
                repeat (int'(v.dly[k])) step();
                pulse_done(v.val[k]);
                gap_exp = int'(v.dly[k]) + GUARD + 2;
            end
        end
        if (!v.exp_err) begin
            check($sformatf("%s.valid_m0", v.name), res_valid, 0);
            step();
            check($sformatf("%s.valid_m1", v.name), res_valid, 0);
            step();
            check($sformatf("%s.valid_m2", v.name), res_valid, 1);
        end else begin
            seen = 1'b0;
            for (int i = 0; i < 400; i++) begin
                step();
                if (res_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            check($sformatf("%s.valid_seen", v.name), seen, 1);
            check($sformatf("%s.retry_gap", v.name), last_gap, TIMEOUT + GUARD + 1);
        end
        check($sformatf("%s.data", v.name), res_data, v.exp_data);
        check($sformatf("%s.error", v.name), res_error, v.exp_err);
        check($sformatf("%s.busy", v.name), busy, 1);
        check($sformatf("%s.arms", v.name), arm_cnt, v.exp_arms);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit bad;
        int n0;
        sess_vec_t restart;

        vecs[0] = mk("nominal",   {32'd106, 32'd104, 32'd102, 32'd100}, {8'd0, 8'd3, 8'd1, 8'd0},  0, 1'b0, 32'd103, 4);
        vecs[1] = mk("truncate",  {32'd2, 32'd1, 32'd1, 32'd1},         {8'd5, 8'd0, 8'd0, 8'd2},  0, 1'b0, 32'd1,   4);
        vecs[2] = mk("one_retry", {32'd40, 32'd30, 32'd20, 32'd10},     {8'd0, 8'd1, 8'd0, 8'd2},  1, 1'b0, 32'd25,  5);
        vecs[3] = mk("coincide",  {32'd8, 32'd8, 32'd8, 32'd9},         {8'd0, 8'd0, 8'd0, 8'd99}, 0, 1'b0, 32'd8,   4);
        vecs[4] = mk("max_value", {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                                  {8'd0, 8'd0, 8'd0, 8'd0}, 0, 1'b0, 32'hFFFF_FFFF, 4);
        vecs[5] = mk("exhaust",   '0, '0, RETRIES, 1'b1, 32'd0, RETRIES);
        restart = mk("restart",   {32'd4, 32'd4, 32'd4, 32'd4},         {8'd0, 8'd0, 8'd0, 8'd0},  0, 1'b0, 32'd4,   4);

        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        meas_done = 1'b0; meas_value = '0; res_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outputs", {meas_arm, res_valid, res_error, busy, sample_idx, res_data}, 0);
        reset_n = 1'b1;
        // A done pulse while idle must be ignored.
        pulse_done(32'd55);
        step();
        check("idle_done_ignored", {meas_arm, res_valid, busy}, 0);

        for (int i = 0; i < 6; i++) begin
            do_session(vecs[i]);
            handshake(vecs[i].name);
        end

        // Backpressure: result held stable and start ignored while not accepted.
        do_session(vecs[0]);
        n0 = arm_cnt;
        for (int i = 0; i < 10; i++) begin
            start = 1'b1;
            step();
            check($sformatf("bp.valid%0d", i), res_valid, 1);
            check($sformatf("bp.data%0d", i), res_data, 103);
            check($sformatf("bp.busy%0d", i), busy, 1);
        end
        start = 1'b0;
        check("bp.no_arm", arm_cnt, n0);
        handshake("bp");

        // Abort in WAIT_MEAS of sample 1, followed by a done that arrives too late.
        arm_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        pulse_done(32'd1000);
        wait_arm(ok);
        check("abort.idx_before", sample_idx, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort.busy", busy, 0);
        check("abort.valid", res_valid, 0);
        pulse_done(32'd5);
        n0  = arm_cnt;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (res_valid || busy) bad = 1'b1;
        end
        check("abort.quiet", bad, 0);
        check("abort.no_arm", arm_cnt, n0);
        do_session(restart);

        // Abort while the result is presented drops it.
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_present.valid", res_valid, 0);
        check("abort_present.busy", busy, 0);

        // Asynchronous reset in the middle of GUARD.
        arm_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        pulse_done(32'd77);
        check("rst_guard.busy_pre", busy, 1);
        check("rst_guard.idx_pre", sample_idx, 1);
        check("rst_guard.data_pre", res_data, 4);
        step();
        #2 reset_n = 1'b0;
        #1 check("rst_guard.async_zero",
                 {meas_arm, res_valid, res_error, busy, sample_idx, res_data}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        step();
        check("rst_guard.idle_after", busy, 0);
        do_session(vecs[1]);
        handshake("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
